// File: rtl/tmds_gearbox.sv
// tmds_gearbox: multi-lane word-to-chunk gearbox for TMDS serializers.
// Buffers CHANNELS-wide word-sets in a small FIFO and emits OUT_W bits per
// lane per clock, LSB first. IDLE_WORD is sent on every lane whenever the
// block is not streaming, including an underflow while running.
// Optional build macro TMDS_GEARBOX_STATS_EN adds a saturating
// underflow counter output (underflow_cnt).
module tmds_gearbox #(
   parameter int                CHANNELS    = 3,
   parameter int                WORD_W      = 10,
   parameter int                OUT_W       = 2,
   parameter int                DEPTH       = 4,
   parameter int                PRIME_LEVEL = 2,
   parameter logic [WORD_W-1:0] IDLE_WORD   = 10'b1101010100
) (
   input  logic                         clk_5x,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CHANNELS*WORD_W-1:0]   in_data,
   output logic [CHANNELS*OUT_W-1:0]    out_data,
   output logic                         out_word_start,
   output logic                         underflow,
   output logic [$clog2(DEPTH+1)-1:0]   fill
`ifdef TMDS_GEARBOX_STATS_EN
   ,
   output logic [15:0]                  underflow_cnt
`endif
);

   localparam int R      = WORD_W / OUT_W;
   localparam int PH_W   = (R > 1) ? $clog2(R) : 1;
   localparam int FILL_W = $clog2(DEPTH + 1);
   localparam int PTR_W  = $clog2(DEPTH);

   // Parameter sanity: these abort elaboration on an unusable configuration.
   if (WORD_W % OUT_W != 0) begin : g_bad_ratio
      $error("tmds_gearbox: WORD_W must be an integer multiple of OUT_W");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("tmds_gearbox: DEPTH must be a power of 2 and at least 2");
   end
   if (PRIME_LEVEL < 1 || PRIME_LEVEL > DEPTH) begin : g_bad_prime
      $error("tmds_gearbox: PRIME_LEVEL must lie in 1..DEPTH");
   end

   typedef logic [CHANNELS-1:0][WORD_W-1:0] word_set_t;
   typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;

   state_t             state, state_next;
   logic [PH_W-1:0]    phase;
   logic               boundary;
   word_set_t          mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   word_set_t          shift;
   word_set_t          load_word;
   logic               push, pop, underflow_next;

   assign boundary  = (phase == '0);
   // in_ready looks only at registered fill, so a pop in the same cycle never
   // opens room for a push into a full FIFO.
   assign in_ready  = !rst && (fill < FILL_W'(DEPTH));
   assign push      = in_valid && in_ready;
   assign load_word = pop ? mem[rd_ptr] : {CHANNELS{IDLE_WORD}};

   // State register.
   always_ff @(posedge clk_5x) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next state, pop and underflow decision; only word boundaries matter.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_next     = state;
      pop            = 1'b0;
      underflow_next = 1'b0;
      if (boundary) begin
         case (state)
            ST_IDLE: begin
               if (enable) state_next = ST_PRIME;
            end
            ST_PRIME: begin
               if (!enable) begin
                  state_next = ST_IDLE;
               end else if (fill >= FILL_W'(PRIME_LEVEL)) begin
                  state_next = ST_RUN;
                  pop        = 1'b1;
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  state_next = ST_IDLE;
               end else if (fill == '0) begin
                  state_next     = ST_PRIME;
                  underflow_next = 1'b1;
               end else begin
                  pop = 1'b1;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Phase counter, word load at boundaries and LSB-first chunk shifting.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_5x) begin
      if (rst) begin
         phase          <= '0;
         shift          <= '0;
         out_data       <= '0;
         out_word_start <= 1'b0;
         underflow      <= 1'b0;
      end else begin
         phase <= (phase == PH_W'(R - 1)) ? '0 : phase + PH_W'(1);
         if (boundary) begin
            for (int c = 0; c < CHANNELS; c++) begin
               out_data[c*OUT_W +: OUT_W] <= load_word[c][OUT_W-1:0];
               shift[c]                   <= load_word[c] >> OUT_W;
            end
            out_word_start <= 1'b1;
            underflow      <= underflow_next;
         end else begin
            for (int c = 0; c < CHANNELS; c++) begin
               out_data[c*OUT_W +: OUT_W] <= shift[c][OUT_W-1:0];
               shift[c]                   <= shift[c] >> OUT_W;
            end
            out_word_start <= 1'b0;
            underflow      <= 1'b0;
         end
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_5x) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fill <= fill + FILL_W'(1);
            2'b01:   fill <= fill - FILL_W'(1);
            default: fill <= fill;
         endcase
      end
   end

   // FIFO storage write port.
   // NOTE: storage is deliberately not reset; reset clears the pointers and
   // fill, which makes any stale contents unreachable.
   always_ff @(posedge clk_5x) begin
      if (push) mem[wr_ptr] <= in_data;
   end

`ifdef TMDS_GEARBOX_STATS_EN
   // Saturating count of underflow pulses, cleared only by reset.
   always_ff @(posedge clk_5x) begin
      if (rst)                                   underflow_cnt <= '0;
      else if (underflow && underflow_cnt != '1) underflow_cnt <= underflow_cnt + 16'd1;
   end
`endif

endmodule
